// File: rtl/tetris_pkg.sv
// Shared types and helpers for the active-piece controller: state encoding,
// tetromino shape table, LFSR seed/taps and shape rotation.
package tetris_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SPAWN  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_LOCK   = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shift Fibonacci form of taps 16,14,13,11 (bits 0,2,3,5 feed bit 15).
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam logic [15:0] SHAPE_I = 16'h00F0;
    localparam logic [15:0] SHAPE_O = 16'h0066;
    localparam logic [15:0] SHAPE_T = 16'h0072;
    localparam logic [15:0] SHAPE_S = 16'h0036;
    localparam logic [15:0] SHAPE_Z = 16'h0063;
    localparam logic [15:0] SHAPE_L = 16'h0074;
    localparam logic [15:0] SHAPE_J = 16'h0071;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {^(v & LFSR_TAPS), v[15:1]};
    endfunction

    function automatic logic [2:0] blk_index(input logic [2:0] raw);
        return (raw == 3'd7) ? 3'd0 : raw;
    endfunction

    function automatic logic [15:0] shape_of(input logic [2:0] idx);
        logic [15:0] s;
        case (idx)
            3'd0:    s = SHAPE_I;
            3'd1:    s = SHAPE_O;
            3'd2:    s = SHAPE_T;
            3'd3:    s = SHAPE_S;
            3'd4:    s = SHAPE_Z;
            3'd5:    s = SHAPE_L;
            3'd6:    s = SHAPE_J;
            default: s = SHAPE_I;
        endcase
        return s;
    endfunction

    // new[4r+c] = old[4c+3-r]
    function automatic logic [15:0] rotate_cw(input logic [15:0] d);
        logic [15:0] r;
        r = 16'h0000;
        for (int row = 0; row < 4; row++) begin
            for (int c = 0; c < 4; c++) begin
                r[4*row+c] = d[4*c+3-row];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tetris_lfsr16.sv
// Free-running 16-bit LFSR; exposes only the low three bits used for shape selection.
module tetris_lfsr16
    import tetris_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    output logic [2:0] rnd
);

    logic [15:0] lfsr_r;

    // Steps every cycle in every controller state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    assign rnd = lfsr_r[2:0];

endmodule

// File: rtl/tetris_blk_ctrl.sv
// Active-piece controller: spawn, gravity and key moves feeding the playfield bitmap.
// Optional macro HARD_DROP_EN: key_drop held in ACTIVE forces a fall every ACTIVE cycle.
module tetris_blk_ctrl
    import tetris_pkg::*;
#(
    parameter int ROW_ADDR_W = 5,
    parameter int COL_ADDR_W = 4,
    parameter int SPEED_FREQ = 50_000_000,
    parameter int SPAWN_COL  = 6,
    parameter int SETTLE     = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  key_left,
    input  logic                  key_right,
    input  logic                  key_rot,
    input  logic                  key_drop,
    input  logic                  cur_blk_act,
    input  logic                  left_en,
    input  logic                  right_en,
    input  logic                  up_en,
    input  logic                  game_over,
    output logic [ROW_ADDR_W-1:0] cur_blk_row,
    output logic [COL_ADDR_W-1:0] cur_blk_col,
    output logic [15:0]           cur_blk_data,
    output logic                  falling_update,
    output logic [2:0]            blk_id,
    output logic                  spawn_pulse
);

    localparam int                     FC_W        = (SPEED_FREQ > 1) ? $clog2(SPEED_FREQ) : 1;
    localparam logic [FC_W-1:0]        FC_LAST     = FC_W'(SPEED_FREQ - 1);
    localparam logic [ROW_ADDR_W-1:0]  ROW_LAST    = {ROW_ADDR_W{1'b1}};
    localparam logic [COL_ADDR_W-1:0]  COL_SPAWN   = COL_ADDR_W'(SPAWN_COL);
    localparam logic [3:0]             SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0]             LOCK_LAST   = 4'd1;

    state_t                  state_r, state_nxt_s;
    logic [3:0]              wait_cnt_r;
    logic [FC_W-1:0]         fall_cnt_r;
    logic                    fall_pend_r, rot_pend_r, left_pend_r, right_pend_r;
    logic                    fall_req_s, fall_tick_s, counting_s, latch_en_s;
    logic                    clr_fall_s, clr_rot_s, clr_left_s, clr_right_s, changed_s;
    logic [ROW_ADDR_W-1:0]   row_nxt_s;
    logic [COL_ADDR_W-1:0]   col_nxt_s;
    logic [15:0]             data_nxt_s;
    logic [2:0]              id_nxt_s, rnd_s;
    logic                    fu_nxt_s, sp_nxt_s;

    tetris_lfsr16 u_lfsr (
        .clk  (clk),
        .rstn (rstn),
        .rnd  (rnd_s)
    );

    assign counting_s  = (state_r == ST_SETTLE) || (state_r == ST_ACTIVE);
    assign fall_tick_s = counting_s && (fall_cnt_r == FC_LAST);
    assign latch_en_s  = (state_r != ST_IDLE) && (state_r != ST_OVER);

`ifdef HARD_DROP_EN
    assign fall_req_s = fall_pend_r | (key_drop & (state_r == ST_ACTIVE));
`else
    logic unused_s;
    assign unused_s   = key_drop;
    assign fall_req_s = fall_pend_r;
`endif

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; changed_s comes from the action arbiter below.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:   state_nxt_s = start ? ST_SPAWN : ST_IDLE;
            ST_SPAWN:  state_nxt_s = ST_SETTLE;
            ST_SETTLE: state_nxt_s = (wait_cnt_r == SETTLE_LAST) ? ST_ACTIVE : ST_SETTLE;
            ST_ACTIVE: begin
                if (game_over)         state_nxt_s = ST_OVER;
                else if (!cur_blk_act) state_nxt_s = ST_LOCK;
                else if (changed_s)    state_nxt_s = ST_SETTLE;
                else                   state_nxt_s = ST_ACTIVE;
            end
            ST_LOCK: begin
                if (game_over)                    state_nxt_s = ST_OVER;
                else if (wait_cnt_r == LOCK_LAST) state_nxt_s = ST_SPAWN;
                else                              state_nxt_s = ST_LOCK;
            end
            ST_OVER:   state_nxt_s = ST_OVER;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Output/arbiter logic: one pending action per ACTIVE cycle, fall > rot > left > right.
    always_comb begin
        row_nxt_s   = cur_blk_row;
        col_nxt_s   = cur_blk_col;
        data_nxt_s  = cur_blk_data;
        id_nxt_s    = blk_id;
        fu_nxt_s    = 1'b0;
        sp_nxt_s    = 1'b0;
        changed_s   = 1'b0;
        clr_fall_s  = 1'b0;
        clr_rot_s   = 1'b0;
        clr_left_s  = 1'b0;
        clr_right_s = 1'b0;
        case (state_r)
            ST_SPAWN: begin
                row_nxt_s  = {ROW_ADDR_W{1'b0}};
                col_nxt_s  = COL_SPAWN;
                id_nxt_s   = blk_index(rnd_s);
                data_nxt_s = shape_of(blk_index(rnd_s));
                sp_nxt_s   = 1'b1;
            end
            ST_ACTIVE: begin
                if (!game_over && cur_blk_act) begin
                    if (fall_req_s) begin
                        clr_fall_s = 1'b1;
                        if (cur_blk_row != ROW_LAST) begin
                            row_nxt_s = cur_blk_row + ROW_ADDR_W'(1);
                            fu_nxt_s  = 1'b1;
                            changed_s = 1'b1;
                        end else begin
                            row_nxt_s = cur_blk_row;
                        end
                    end else if (rot_pend_r) begin
                        clr_rot_s = 1'b1;
                        if (up_en) begin
                            data_nxt_s = rotate_cw(cur_blk_data);
                            changed_s  = 1'b1;
                        end else begin
                            data_nxt_s = cur_blk_data;
                        end
                    end else if (left_pend_r) begin
                        clr_left_s = 1'b1;
                        if (left_en) begin
                            col_nxt_s = cur_blk_col - COL_ADDR_W'(1);
                            changed_s = 1'b1;
                        end else begin
                            col_nxt_s = cur_blk_col;
                        end
                    end else if (right_pend_r) begin
                        clr_right_s = 1'b1;
                        if (right_en) begin
                            col_nxt_s = cur_blk_col + COL_ADDR_W'(1);
                            changed_s = 1'b1;
                        end else begin
                            col_nxt_s = cur_blk_col;
                        end
                    end else begin
                        changed_s = 1'b0;
                    end
                end else begin
                    changed_s = 1'b0;
                end
            end
            default: changed_s = 1'b0;
        endcase
    end

    // SETTLE/LOCK dwell counter restarts on every state change.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt_r <= 4'd0;
        end else if (state_nxt_s != state_r) begin
            wait_cnt_r <= 4'd0;
        end else if ((state_r == ST_SETTLE) || (state_r == ST_LOCK)) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Gravity timer runs only while a piece is settling or active.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fall_cnt_r <= {FC_W{1'b0}};
        end else if (state_r == ST_SPAWN) begin
            fall_cnt_r <= {FC_W{1'b0}};
        end else if (counting_s) begin
            fall_cnt_r <= fall_tick_s ? {FC_W{1'b0}} : fall_cnt_r + FC_W'(1);
        end else begin
            fall_cnt_r <= fall_cnt_r;
        end
    end

    // Pending requests: latched outside IDLE/OVER, flushed on spawn, dropped once served.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fall_pend_r  <= 1'b0;
            rot_pend_r   <= 1'b0;
            left_pend_r  <= 1'b0;
            right_pend_r <= 1'b0;
        end else if (state_r == ST_SPAWN) begin
            fall_pend_r  <= 1'b0;
            rot_pend_r   <= 1'b0;
            left_pend_r  <= 1'b0;
            right_pend_r <= 1'b0;
        end else if (latch_en_s) begin
            fall_pend_r  <= (fall_pend_r  & ~clr_fall_s)  | fall_tick_s;
            rot_pend_r   <= (rot_pend_r   & ~clr_rot_s)   | key_rot;
            left_pend_r  <= (left_pend_r  & ~clr_left_s)  | key_left;
            right_pend_r <= (right_pend_r & ~clr_right_s) | key_right;
        end else begin
            fall_pend_r  <= fall_pend_r;
            rot_pend_r   <= rot_pend_r;
            left_pend_r  <= left_pend_r;
            right_pend_r <= right_pend_r;
        end
    end

    // Registered piece outputs toward the bitmap stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_blk_row    <= {ROW_ADDR_W{1'b0}};
            cur_blk_col    <= COL_SPAWN;
            cur_blk_data   <= 16'h0000;
            blk_id         <= 3'd0;
            falling_update <= 1'b0;
            spawn_pulse    <= 1'b0;
        end else begin
            cur_blk_row    <= row_nxt_s;
            cur_blk_col    <= col_nxt_s;
            cur_blk_data   <= data_nxt_s;
            blk_id         <= id_nxt_s;
            falling_update <= fu_nxt_s;
            spawn_pulse    <= sp_nxt_s;
        end
    end

endmodule

// File: tb/tb_tetris_blk_ctrl.sv
// Directed self-checking bench for tetris_blk_ctrl (SPEED_FREQ=8, default build).
module tb_tetris_blk_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0, key_left = 1'b0, key_right = 1'b0, key_rot = 1'b0, key_drop = 1'b0;
    logic        cur_blk_act = 1'b1, left_en = 1'b1, right_en = 1'b1, up_en = 1'b1, game_over = 1'b0;
    logic [4:0]  cur_blk_row;
    logic [3:0]  cur_blk_col;
    logic [15:0] cur_blk_data;
    logic        falling_update;
    logic [2:0]  blk_id;
    logic        spawn_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_lfsr, m_prev;

    tetris_blk_ctrl #(
        .ROW_ADDR_W (5),
        .COL_ADDR_W (4),
        .SPEED_FREQ (8),
        .SPAWN_COL  (6),
        .SETTLE     (2)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start          (start),
        .key_left       (key_left),
        .key_right      (key_right),
        .key_rot        (key_rot),
        .key_drop       (key_drop),
        .cur_blk_act    (cur_blk_act),
        .left_en        (left_en),
        .right_en       (right_en),
        .up_en          (up_en),
        .game_over      (game_over),
        .cur_blk_row    (cur_blk_row),
        .cur_blk_col    (cur_blk_col),
        .cur_blk_data   (cur_blk_data),
        .falling_update (falling_update),
        .blk_id         (blk_id),
        .spawn_pulse    (spawn_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    function automatic logic [2:0] ref_idx(input logic [15:0] v);
        logic [2:0] r;
        r = v[2:0];
        return (r == 3'd7) ? 3'd0 : r;
    endfunction

    function automatic logic [15:0] ref_shape(input logic [2:0] i);
        case (i)
            3'd0: return 16'h00F0;
            3'd1: return 16'h0066;
            3'd2: return 16'h0072;
            3'd3: return 16'h0036;
            3'd4: return 16'h0063;
            3'd5: return 16'h0074;
            3'd6: return 16'h0071;
            default: return 16'h00F0;
        endcase
    endfunction

    // Reference LFSR tracking the generator cycle by cycle.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_lfsr <= ref_lfsr(m_lfsr);
            m_prev <= m_lfsr;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fall(input int limit, output int cyc);
        cyc = 0;
        while (cyc < limit) begin
            step_clk();
            cyc++;
            if (falling_update) break;
        end
    endtask

    task automatic wait_col_change(input logic [3:0] from, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (cur_blk_col != from) break;
            step_clk();
        end
    endtask

    initial begin
        int          cyc;
        bit          hit;
        logic [15:0] nxt;
        logic [4:0]  row_q, exp_row;
        logic [3:0]  col_q, exp_col;
        logic [2:0]  exp_id;
        logic [15:0] exp_data;

        #12;
        check_val("rst_row", cur_blk_row, 5'd0);
        check_val("rst_col", cur_blk_col, 4'd6);
        check_val("rst_data", cur_blk_data, 16'h0000);
        check_val("rst_id", blk_id, 3'd0);
        check_val("rst_fu", falling_update, 1'b0);
        check_val("rst_sp", spawn_pulse, 1'b0);
        rstn = 1'b1;
        step_clk();

        // Start so that the SPAWN cycle sees lfsr[2:0]==2 (T piece).
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            nxt = ref_lfsr(m_lfsr);
            if (nxt[2:0] == 3'd2) hit = 1'b1;
            else step_clk();
        end
        check_val("lfsr_seek", hit, 1'b1);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        step_clk();
        check_val("spawn_sp", spawn_pulse, 1'b1);
        check_val("spawn_data", cur_blk_data, 16'h0072);
        check_val("spawn_row", cur_blk_row, 5'd0);
        check_val("spawn_col", cur_blk_col, 4'd6);
        check_val("spawn_id", blk_id, 3'd2);

        // Gravity: first fall 9 cycles after spawn, then every 8.
        wait_fall(30, cyc);
        check_val("fall1_lat", cyc, 9);
        check_val("fall1_row", cur_blk_row, 5'd1);
        wait_fall(30, cyc);
        check_val("fall2_period", cyc, 8);
        check_val("fall2_row", cur_blk_row, 5'd2);

        // Rotate T: new[4r+c] = old[4c+3-r].
        key_rot = 1'b1;
        step_clk();
        key_rot = 1'b0;
        for (int i = 0; i < 10 && cur_blk_data == 16'h0072; i++) step_clk();
        check_val("rot_data", cur_blk_data, 16'h2320);

        // Walk left to column 0, then wrap to 15.
        for (int k = 0; k < 7; k++) begin
            col_q   = cur_blk_col;
            exp_col = col_q - 4'd1;
            key_left = 1'b1;
            step_clk();
            key_left = 1'b0;
            wait_col_change(col_q, 20);
            check_val((k == 6) ? "left_wrap" : "left_step", cur_blk_col, exp_col);
        end

        // Blocked left: no move, and request must be dropped.
        left_en  = 1'b0;
        key_left = 1'b1;
        step_clk();
        key_left = 1'b0;
        repeat (12) step_clk();
        check_val("left_blocked", cur_blk_col, 4'd15);
        left_en = 1'b1;
        repeat (12) step_clk();
        check_val("left_dropped", cur_blk_col, 4'd15);

        // Fall tick coinciding with key_right: fall first, right after SETTLE.
        wait_fall(30, cyc);
        check_val("fall3_seen", falling_update, 1'b1);
        wait_fall(30, cyc);
        check_val("fall4_period", cyc, 8);
        repeat (6) step_clk();
        key_right = 1'b1;
        step_clk();
        key_right = 1'b0;
        row_q   = cur_blk_row;
        col_q   = cur_blk_col;
        exp_row = row_q + 5'd1;
        exp_col = col_q + 4'd1;
        step_clk();
        check_val("coinc_fu", falling_update, 1'b1);
        check_val("coinc_row", cur_blk_row, exp_row);
        check_val("coinc_col_hold", cur_blk_col, col_q);
        repeat (2) step_clk();
        check_val("coinc_col_settle", cur_blk_col, col_q);
        step_clk();
        check_val("coinc_col_right", cur_blk_col, exp_col);

        // Drop act: ACTIVE after SETTLE, LOCK 2 cycles, then respawn.
        cur_blk_act = 1'b0;
        row_q = cur_blk_row;
        repeat (5) step_clk();
        check_val("lock_sp", spawn_pulse, 1'b0);
        check_val("lock_row_hold", cur_blk_row, row_q);
        step_clk();
        cur_blk_act = 1'b1;
        exp_id   = ref_idx(m_prev);
        exp_data = ref_shape(exp_id);
        check_val("respawn_sp", spawn_pulse, 1'b1);
        check_val("respawn_row", cur_blk_row, 5'd0);
        check_val("respawn_col", cur_blk_col, 4'd6);
        check_val("respawn_id", blk_id, exp_id);
        check_val("respawn_data", cur_blk_data, exp_data);

        // Game over: outputs frozen despite keys and elapsed gravity time.
        game_over = 1'b1;
        repeat (3) step_clk();
        key_left = 1'b1;
        key_rot  = 1'b1;
        start    = 1'b1;
        step_clk();
        key_left = 1'b0;
        key_rot  = 1'b0;
        start    = 1'b0;
        repeat (20) step_clk();
        check_val("over_row", cur_blk_row, 5'd0);
        check_val("over_col", cur_blk_col, 4'd6);
        check_val("over_data", cur_blk_data, exp_data);
        check_val("over_id", blk_id, exp_id);
        check_val("over_fu", falling_update, 1'b0);
        check_val("over_sp", spawn_pulse, 1'b0);

        // Exit via reset, spawn again, then reset mid-SETTLE.
        rstn = 1'b0;
        step_clk();
        rstn = 1'b1;
        game_over = 1'b0;
        step_clk();
        start = 1'b1;
        step_clk();
        start = 1'b0;
        step_clk();
        check_val("rst2_spawn", spawn_pulse, 1'b1);
        step_clk();
        #2;
        rstn = 1'b0;
        #1;
        check_val("midrst_row", cur_blk_row, 5'd0);
        check_val("midrst_col", cur_blk_col, 4'd6);
        check_val("midrst_data", cur_blk_data, 16'h0000);
        check_val("midrst_id", blk_id, 3'd0);
        check_val("midrst_fu", falling_update, 1'b0);
        check_val("midrst_sp", spawn_pulse, 1'b0);
        step_clk();
        rstn = 1'b1;
        repeat (5) step_clk();
        check_val("idle_after_rst", cur_blk_data, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
